// File: rtl/mio_bus_arbiter.sv
// Shares one MIO memory port between the instruction-fetch and MEM-stage data
// requesters: one latched transaction at a time, registered bus drive, ack pulse.
module mio_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic               last_d_q, last_d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               bus_error_q, bus_error_d;
  logic [31:0]        cap_data;

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_error_d = bus_error_q;
    cap_data    = mem_rdata;

    unique case (state_q)
      IDLE: begin
        // Data normally wins a tie; fetch wins if data had the previous grant.
        if (d_req && (!if_req || !last_d_q)) begin
          state_d  = DBUS;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          cnt_d    = '0;
          last_d_d = 1'b1;
        end else if (if_req) begin
          state_d  = IBUS;
          addr_d   = if_addr;
          we_d     = 1'b0;
          cnt_d    = '0;
          last_d_d = 1'b0;
        end
      end
      IBUS, DBUS: begin
        if (mem_ready) begin
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          cap_data    = ERR_DATA;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d == DONE) begin
          if (state_q == DBUS) d_rdata_d  = cap_data;
          else                 if_rdata_d = cap_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  // The granted port is recoverable from last_d in DONE, so acks need no extra flop.
  assign mem_req   = (state_q == IBUS) || (state_q == DBUS);
  assign mem_we    = (state_q == DBUS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == DONE) && !last_d_q;
  assign d_ack     = (state_q == DONE) && last_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_error = bus_error_q;
  assign if_stall  = if_req & ~if_ack;
  assign d_stall   = d_req & ~d_ack;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbitration rules.
module tb_mio_bus_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we, bus_error;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state.
  bit          last_d_m;
  bit          err_m;
  logic [31:0] m_if_rdata, m_d_rdata;

  mio_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    #1;
    check("idle_mem_req", mem_req, 1'b0);
    check("idle_if_ack", if_ack, 1'b0);
    check("idle_d_ack", d_ack, 1'b0);
  endtask

  // Called in the IDLE cycle with requests already driven; runs one transaction
  // whose bus answers after w wait cycles (w > TO means it never answers).
  task automatic txn(input int w, input logic [31:0] rd, output bit won_d);
    bit          pick_d, tmo, exp_we;
    int          lat;
    logic [31:0] a, wd;
    pick_d = d_req && (!if_req || !last_d_m);
    tmo    = (w > TO);
    lat    = tmo ? TO + 2 : w + 2;
    a      = pick_d ? d_addr : if_addr;
    wd     = d_wdata;
    exp_we = pick_d && d_we;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("req_if_stall", if_stall, if_req);
    check("req_d_stall", d_stall, d_req);
    check("req_mem_req", mem_req, 1'b0);
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      if (c == lat) mem_ready = 1'($urandom_range(0, 1));
      else          mem_ready = !tmo && (c == w + 1);
      mem_rdata = (mem_ready && c < lat) ? rd : $urandom;
      #1;
      if (c < lat) begin
        check("bus_mem_req", mem_req, 1'b1);
        check("bus_mem_we", mem_we, exp_we);
        check("bus_mem_addr", mem_addr, a);
        if (exp_we) check("bus_mem_wdata", mem_wdata, wd);
        check("bus_if_ack", if_ack, 1'b0);
        check("bus_d_ack", d_ack, 1'b0);
        check("bus_if_stall", if_stall, if_req);
        check("bus_d_stall", d_stall, d_req);
        check("bus_error_hold", bus_error, err_m);
      end else begin
        err_m = err_m | tmo;
        if (pick_d) m_d_rdata  = tmo ? ERR : rd;
        else        m_if_rdata = tmo ? ERR : rd;
        check("done_mem_req", mem_req, 1'b0);
        check("done_mem_we", mem_we, 1'b0);
        check("done_if_ack", if_ack, !pick_d);
        check("done_d_ack", d_ack, pick_d);
        check("done_if_rdata", if_rdata, m_if_rdata);
        check("done_d_rdata", d_rdata, m_d_rdata);
        check("done_if_stall", if_stall, if_req && pick_d);
        check("done_d_stall", d_stall, d_req && !pick_d);
        check("done_bus_error", bus_error, err_m);
      end
    end
    last_d_m = pick_d;
    won_d    = pick_d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_if_ack"}, if_ack, 1'b0);
    check({tag, "_d_ack"}, d_ack, 1'b0);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
    check({tag, "_bus_error"}, bus_error, 1'b0);
  endtask

  initial begin
    bit won;
    int n_if, n_d;
    rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    last_d_m = 0; err_m = 0; m_if_rdata = 0; m_d_rdata = 0;

    // Reset state.
    repeat (3) next_cycle();
    check_all_zero("rst");
    check("rst_if_stall", if_stall, 1'b0);
    check("rst_d_stall", d_stall, 1'b0);
    rst = 1'b1;

    // Fetch alone, zero-wait bus.
    next_cycle();
    if_req = 1; if_addr = 32'h0000_0040;
    txn(0, 32'h2008_0005, won);
    check("fetch_rdata_value", if_rdata, 32'h2008_0005);

    // Store with three wait cycles.
    next_cycle();
    if_req = 0;
    d_req = 1; d_we = 1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D;
    txn(3, 32'h1234_5678, won);
    check("store_won_d", won, 1'b1);

    // Fetch to hand the next tie to data.
    next_cycle();
    d_req = 0; d_we = 0;
    if_req = 1; if_addr = 32'h0000_0044;
    txn(1, $urandom, won);

    // Both held: grants alternate D, I, D, I ...
    n_if = 0; n_d = 0;
    next_cycle();
    if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h0000_0200; if_addr = 32'h0000_0048;
    for (int i = 0; i < 8; i++) begin
      txn(int'($urandom_range(0, 2)), $urandom, won);
      check("alt_grant", won, (i % 2) == 0);
      if (won) n_d++; else n_if++;
      next_cycle();
      if (won) d_addr  = d_addr + 32'd4;
      else     if_addr = if_addr + 32'd4;
    end
    check("alt_if_acks", n_if, 4);
    check("alt_d_acks", n_d, 4);

    // Timed-out load, then good transactions keep the sticky flag.
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h0000_0300;
    txn(100, $urandom, won);
    check("tmo_d_rdata", d_rdata, ERR);
    check("tmo_bus_error", bus_error, 1'b1);
    next_cycle();
    d_req = 0; if_req = 1; if_addr = 32'h0000_0050;
    txn(0, $urandom, won);
    next_cycle();
    if_req = 0; d_req = 1; d_we = 1; d_addr = 32'h0000_0304; d_wdata = $urandom;
    txn(2, $urandom, won);
    check("sticky_bus_error", bus_error, 1'b1);

    // Reset pulsed during the second wait cycle of a store.
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 32'h0000_0400; d_wdata = 32'h5555_AAAA;
    mem_ready = 0;
    next_cycle();
    check("pre_rst_mem_we", mem_we, 1'b1);
    next_cycle();
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      check("inrst_d_ack", d_ack, 1'b0);
      check("inrst_mem_req", mem_req, 1'b0);
    end
    rst = 1'b1; d_req = 0; d_we = 0;
    last_d_m = 0; err_m = 0; m_if_rdata = 0; m_d_rdata = 0;
    next_cycle();
    d_req = 1; d_we = 0; d_addr = 32'h0000_0400;
    txn(1, 32'h0BAD_F00D, won);
    check("reissue_d_rdata", d_rdata, 32'h0BAD_F00D);

    // Randomized traffic against the model.
    won = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (won) d_req = 0; else if_req = 0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (!if_req && !d_req) idle_cycle();
      else txn(int'($urandom_range(0, 5)), $urandom, won);
    end

    next_cycle();
    if_req = 0; d_req = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
